// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, sampled debounce,
// and per-channel press/release/long-press/auto-repeat pulse generation.
module button_conditioner #(
  parameter int CH           = 3,
  parameter int DB_LEN       = 4,
  parameter int SAMPLE_DIV   = 1,
  parameter int HOLD_TICKS   = 50_000_000,
  parameter int REPEAT_TICKS = 10_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] btn_in,
  input  logic [CH-1:0] repeat_en,
  output logic [CH-1:0] level,
  output logic [CH-1:0] press,
  output logic [CH-1:0] release_pulse,  // "release" and "repeat" are reserved words
  output logic [CH-1:0] long_press,
  output logic [CH-1:0] repeat_pulse,
  output logic          any_press
);

  localparam int PW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int MAXT = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic [CH-1:0]     sync1_r;
  logic [CH-1:0]     sync2_r;
  logic [PW-1:0]     pre_cnt_r;
  logic              tick_s;
  logic [DB_LEN-1:0] sh_r    [CH];
  logic [CH-1:0]     rise_s;
  logic [CH-1:0]     fall_s;
  state_t            state_r [CH];
  state_t            state_s [CH];
  logic [CW-1:0]     cnt_r   [CH];
  logic [CW-1:0]     cnt_s   [CH];
  logic [CH-1:0]     long_s;
  logic [CH-1:0]     rpt_s;

  assign tick_s = (pre_cnt_r == PRE_LAST);

  for (genvar g = 0; g < CH; g++) begin : g_edge
    assign rise_s[g] = (&sh_r[g]) & ~level[g];
    assign fall_s[g] = ~(|sh_r[g]) & level[g];
  end

  // Input synchroniser, runs every clock independent of the sample tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Sample prescaler; with SAMPLE_DIV=1 the count stays 0 and tick is constant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_r <= '0;
    end else if (tick_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1'b1);
    end
  end

  // Sample shift registers, debounced level, FSM state and registered pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      long_press    <= '0;
      repeat_pulse  <= '0;
      any_press     <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        sh_r[i]    <= '0;
        state_r[i] <= IDLE;
        cnt_r[i]   <= '0;
      end
    end else begin
      level         <= (level | rise_s) & ~fall_s;
      press         <= rise_s;
      release_pulse <= fall_s;
      long_press    <= long_s;
      repeat_pulse  <= rpt_s;
      any_press     <= |rise_s;
      for (int i = 0; i < CH; i++) begin
        if (tick_s) begin
          sh_r[i] <= {sh_r[i][DB_LEN-2:0], sync2_r[i]};
        end
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
    end
  end

  // Per-channel hold FSM; a debounced fall always wins over long/repeat pulses
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      long_s[i]  = 1'b0;
      rpt_s[i]   = 1'b0;
      case (state_r[i])
        IDLE: begin
          if (rise_s[i]) begin
            state_s[i] = PRESSED;
            cnt_s[i]   = '0;
          end else begin
            state_s[i] = IDLE;
          end
        end
        PRESSED: begin
          if (fall_s[i]) begin
            state_s[i] = IDLE;
            cnt_s[i]   = '0;
          end else if (tick_s) begin
            if (cnt_r[i] == HOLD_LAST) begin
              long_s[i]  = 1'b1;
              cnt_s[i]   = '0;
              state_s[i] = HELD;
            end else begin
              cnt_s[i] = cnt_r[i] + CW'(1'b1);
            end
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end
        HELD: begin
          if (fall_s[i]) begin
            state_s[i] = IDLE;
            cnt_s[i]   = '0;
          end else if (!repeat_en[i]) begin
            cnt_s[i] = '0;
          end else if (tick_s) begin
            if (cnt_r[i] == RPT_LAST) begin
              rpt_s[i] = 1'b1;
              cnt_s[i] = '0;
            end else begin
              cnt_s[i] = cnt_r[i] + CW'(1'b1);
            end
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end
        default: begin
          state_s[i] = IDLE;
          cnt_s[i]   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed plan steps plus a
// randomized phase, all checked against a timestamp-based reference model.
module tb_button_conditioner;

  localparam int CH   = 3;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int RPT  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] btn_in, repeat_en;
  logic [CH-1:0] level, press, release_pulse, long_press, repeat_pulse;
  logic          any_press;

  logic [CH-1:0] btn3, ren3;
  logic [CH-1:0] level3, press3, release3, long3, repeat3;
  logic          any3;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  // reference model state
  logic [CH-1:0] m_level, m_press, m_rel, m_long, m_rpt;
  logic          m_any;
  logic [CH-1:0] m_d1, m_d2;        // btn_in seen one / two edges ago
  logic [CH-1:0] m_run_val;
  int            m_run_len   [CH];
  int            m_press_edge[CH];
  int            m_anchor    [CH];
  bit            m_held      [CH];

  always #5 clk = ~clk;

  button_conditioner #(
    .CH(CH), .DB_LEN(DB), .SAMPLE_DIV(1), .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
    .level(level), .press(press), .release_pulse(release_pulse),
    .long_press(long_press), .repeat_pulse(repeat_pulse), .any_press(any_press)
  );

  button_conditioner #(
    .CH(CH), .DB_LEN(DB), .SAMPLE_DIV(3), .HOLD_TICKS(HOLD), .REPEAT_TICKS(RPT)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn3), .repeat_en(ren3),
    .level(level3), .press(press3), .release_pulse(release3),
    .long_press(long3), .repeat_pulse(repeat3), .any_press(any3)
  );

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, edge_n);
    end
  endtask

  // Model of one clock edge for the SAMPLE_DIV=1 instance, using inputs present at the edge.
  task automatic model_edge();
    logic smp;
    edge_n++;
    m_press = '0; m_rel = '0; m_long = '0; m_rpt = '0;
    if (!rst_n) begin
      m_level = '0; m_d1 = '0; m_d2 = '0; m_run_val = '0;
      for (int c = 0; c < CH; c++) begin
        m_run_len[c] = DB; m_held[c] = 1'b0; m_press_edge[c] = 0; m_anchor[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        smp = m_d2[c];
        if (m_run_len[c] >= DB && m_run_val[c] != m_level[c]) begin
          if (m_run_val[c]) begin
            m_press[c] = 1'b1; m_press_edge[c] = edge_n; m_held[c] = 1'b0;
          end else begin
            m_rel[c] = 1'b1;
          end
          m_level[c] = m_run_val[c];
        end else if (m_level[c]) begin
          if (!m_held[c]) begin
            if (edge_n - m_press_edge[c] == HOLD) begin
              m_long[c] = 1'b1; m_held[c] = 1'b1; m_anchor[c] = edge_n;
            end
          end else if (!repeat_en[c]) begin
            m_anchor[c] = edge_n;
          end else if (edge_n - m_anchor[c] == RPT) begin
            m_rpt[c] = 1'b1; m_anchor[c] = edge_n;
          end
        end
        if (smp == m_run_val[c]) begin
          m_run_len[c] = (m_run_len[c] < DB) ? m_run_len[c] + 1 : DB;
        end else begin
          m_run_val[c] = smp; m_run_len[c] = 1;
        end
      end
      m_d2 = m_d1;
      m_d1 = btn_in;
    end
    m_any = |m_press;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("level", level, m_level);
    chk("press", press, m_press);
    chk("release", release_pulse, m_rel);
    chk("long_press", long_press, m_long);
    chk("repeat", repeat_pulse, m_rpt);
    chk_int("any_press", int'(any_press), int'(m_any));
  endtask

  initial begin : stim
    int p_at, p_cnt, long_at, rel_at, rpt_after, first_rpt, lat;
    int rq[$];
    logic acc;
    logic [CH-1:0] other;

    rst_n = 1'b0; btn_in = '0; repeat_en = '0; btn3 = '0; ren3 = '0;
    step(); step();
    chk("reset_outputs", level | press | release_pulse | long_press | repeat_pulse, 3'b000);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // 1: single press on channel 0
    btn_in[0] = 1'b1; p_at = 0; p_cnt = 0; other = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (press[0]) begin p_at = k; p_cnt++; end
      other = other | level[2:1] | press[2:1];
    end
    chk_int("t1_press_edge", p_at, 7);
    chk_int("t1_press_width", p_cnt, 1);
    chk("t1_other_channels", other, 3'b000);
    btn_in[0] = 1'b0;
    for (int k = 0; k < 12; k++) step();

    // 2: bouncing channel 1 never resolves
    acc = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) btn_in[1] = ~btn_in[1];
      step();
      acc = acc | level[1] | press[1] | release_pulse[1];
    end
    btn_in[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      acc = acc | level[1] | press[1] | release_pulse[1];
    end
    chk_int("t2_bounce_rejected", int'(acc), 0);

    // 3: long press with auto-repeat on channel 2
    repeat_en[2] = 1'b1; btn_in[2] = 1'b1; long_at = 0; rq.delete();
    for (int k = 1; k <= 30; k++) begin
      step();
      if (long_press[2]) long_at = k;
      if (repeat_pulse[2]) rq.push_back(k);
    end
    chk_int("t3_long_edge", long_at, 17);
    chk_int("t3_repeat_count", rq.size(), 3);
    chk_int("t3_repeat0", (rq.size() > 0) ? rq[0] : -1, 21);
    chk_int("t3_repeat1", (rq.size() > 1) ? rq[1] : -1, 25);
    chk_int("t3_repeat2", (rq.size() > 2) ? rq[2] : -1, 29);
    btn_in[2] = 1'b0; rel_at = 0; rpt_after = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (release_pulse[2]) rel_at = k;
      if (repeat_pulse[2] && rel_at != 0) rpt_after++;
    end
    chk_int("t3_release_edge", rel_at, 7);
    chk_int("t3_no_repeat_after_release", rpt_after, 0);

    // 4: long press with repeat disabled, then enabled after edge 30
    repeat_en[2] = 1'b0; btn_in[2] = 1'b1; long_at = 0; first_rpt = 0;
    for (int k = 1; k <= 36; k++) begin
      step();
      if (long_press[2]) long_at = k;
      if (repeat_pulse[2] && first_rpt == 0) first_rpt = k;
      if (k == 30) repeat_en[2] = 1'b1;
    end
    chk_int("t4_long_edge", long_at, 17);
    chk_int("t4_first_repeat", first_rpt, 34);
    btn_in[2] = 1'b0;
    for (int k = 0; k < 14; k++) step();

    // 5: reset in the middle of a hold, button still pressed afterwards
    btn_in[0] = 1'b1;
    for (int k = 0; k < 20; k++) step();
    rst_n = 1'b0;
    step();
    chk("t5_reset_clears", level | press | release_pulse | long_press | repeat_pulse, 3'b000);
    rst_n = 1'b1; p_at = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (press[0]) p_at = k;
    end
    chk_int("t5_press_after_reset", p_at, 7);
    btn_in[0] = 1'b0;
    for (int k = 0; k < 12; k++) step();

    // randomized phase against the reference model
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(11) == 0) btn_in[c] = ~btn_in[c];
        if ($urandom_range(19) == 0) repeat_en[c] = ~repeat_en[c];
      end
      rst_n = ($urandom_range(299) != 0);
      step();
    end
    rst_n = 1'b1; btn_in = '0;
    for (int k = 0; k < 12; k++) step();

    // 6: SAMPLE_DIV=3 instance, glitch rejection then a steady press
    btn3[0] = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      acc = acc | (|level3) | (|press3) | (|release3) | (|long3) | (|repeat3) | any3;
    end
    btn3[0] = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      acc = acc | (|level3) | (|press3) | (|release3) | (|long3) | (|repeat3) | any3;
    end
    chk_int("t6_glitch_rejected", int'(acc), 0);
    btn3[0] = 1'b1; lat = 0; p_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (level3[0] && lat == 0) lat = k;
      if (press3[0]) p_cnt++;
    end
    chk_int("t6_latency_in_bound", int'(lat >= 1 && lat <= 2 + 3 * (DB + 1)), 1);
    chk_int("t6_press_width", p_cnt, 1);
    chk("t6_level_held", level3, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Parametrised multi-channel successor to the per-button Debounce + OnePulse pairs used at the board top level. Each of CH raw push-button inputs is synchronised, debounced with a configurable sample rate and depth, and turned into single-cycle press and release pulses. Each channel also produces a long-press pulse and an optional auto-repeat pulse train. The block sits between board pins and game/control logic such as reset, start, enter and digit entry.

Parameters:
CH, 3, number of independent button channels (>=1)
DB_LEN, 4, consecutive identical samples required to change debounced level (>=2)
SAMPLE_DIV, 1, clocks per sample tick (>=1; 1 = sample every clock)
HOLD_TICKS, 50_000_000, sample ticks after press before long_press fires (>=1)
REPEAT_TICKS, 10_000_000, sample ticks between auto-repeat pulses after long press (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
btn_in  in  CH  raw asynchronous button levels, active-high
repeat_en  in  CH  per-channel auto-repeat enable, sampled on ticks
level  out  CH  debounced button level
press  out  CH  1-clk pulse on debounced rise
release  out  CH  1-clk pulse on debounced fall
long_press  out  CH  1-clk pulse when held HOLD_TICKS ticks
repeat  out  CH  1-clk auto-repeat pulses while held past long press
any_press  out  1  OR of press, same cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): sync FFs, shift registers, prescaler, counters and all outputs go to 0; FSMs go to IDLE. Reset has priority over all other activity, including mid-hold.
- Synchroniser: 2-FF per channel, every clock regardless of tick.
- Prescaler: counts 0..SAMPLE_DIV-1. tick=1 when count==SAMPLE_DIV-1, then wraps to 0. With SAMPLE_DIV=1, tick is constant 1.
- Shift register: on tick, shift the synchronised bit into sh[DB_LEN-1:0].
- Debounce:
  - On the edge after sh becomes all-ones with level=0: level<=1 and press<=1.
  - On the edge after sh becomes all-zeros with level=1: level<=0 and release<=1.
  - Mixed sh: no change.
- Latency (SAMPLE_DIV=1): counting the first edge that sees btn_in=1 as edge 1, level and press are high after edge DB_LEN+3. Release latency is symmetric.
- All pulse outputs are exactly 1 clk wide for any SAMPLE_DIV.
- Per-channel FSM, with a hold counter whose width is clog2(max(HOLD_TICKS,REPEAT_TICKS)+1):
  - IDLE: waits for the debounced rise. On rise: counter<=0, go to PRESSED.
  - PRESSED: counter increments on each tick. When it reaches HOLD_TICKS: long_press pulse, counter<=0, go to HELD.
  - HELD, repeat_en=1: counter increments on each tick. When it reaches REPEAT_TICKS: repeat pulse, counter<=0.
  - HELD, repeat_en=0: counter held at 0, no repeat pulses. Repeats resume REPEAT_TICKS ticks after repeat_en returns to 1.
  - Debounced fall in PRESSED or HELD: release pulse, counter<=0, go to IDLE.
  - A short press (released before HOLD_TICKS) produces press and release only.
- Counter never exceeds its threshold; no wrap-around.
- Channels are fully independent; simultaneous presses on several channels assert their press bits in the same cycle, and any_press=1.
- press and release on the same channel can never coincide. long_press and release can never coincide: release wins and long_press is suppressed.
- A button already held when reset deasserts is treated as a new press after the normal debounce latency.

Test Plan:
(Parameters: CH=3, DB_LEN=4, SAMPLE_DIV=1, HOLD_TICKS=10, REPEAT_TICKS=4)
1. btn_in[0] 0->1 and held 20 clks -> level[0] high after edge 7; press[0] and any_press high for exactly 1 clk at edge 7; channels 1 and 2 stay 0.
2. btn_in[1] toggled every 2 clks for 24 clks, then held low -> level[1], press[1] and release[1] never assert.
3. btn_in[2] held with repeat_en[2]=1 -> press at edge 7; long_press at edge 17; repeat at edges 21, 25, 29; on release, release[2] fires 7 edges after btn_in falls and no further repeats occur.
4. Same as 3 with repeat_en[2]=0 -> long_press once at edge 17 and no repeat pulses. Raising repeat_en at edge 30 -> first repeat at edge 34.
5. btn_in[0] held into HELD state, then rst_n=0 for 1 clk -> all outputs 0 on the next edge. With btn_in still high, a new press[0] fires 7 edges after reset releases.
6. SAMPLE_DIV=3 -> a glitch of 9 clks is rejected with no level change; a steady press gives level high within 2+3*(DB_LEN+1) clks and a press pulse exactly 1 clk wide.
